// File: rtl/sc_frog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_frog_pkg : shared states, direction codes and width helper for the frog mover
// Revision    : 1.0
// ---------------------------------------------------------------------------
package sc_frog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MOVE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Bits needed to index n items, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Maps a direction code onto the {up, down, left, right} pressed-vector layout.
  function automatic logic [3:0] dir_mask(input logic [1:0] d);
    logic [3:0] m;
    m = 4'b0000;
    case (d)
      DIR_UP:    m = 4'b1000;
      DIR_DOWN:  m = 4'b0100;
      DIR_LEFT:  m = 4'b0010;
      DIR_RIGHT: m = 4'b0001;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_frog_move_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_frog_move_ctrl_if : button inputs and position/pulse outputs of the frog mover
// Revision             : 1.0
// ---------------------------------------------------------------------------
interface sc_frog_move_ctrl_if #(
  parameter int COLS = 8,
  parameter int ROWS = 8
);
  import sc_frog_pkg::*;

  localparam int CW = width_of(COLS);
  localparam int RW = width_of(ROWS);

  logic            SC_FROGMOVE_startGame_InLow;
  logic            SC_FROGMOVE_upButton_InLow;
  logic            SC_FROGMOVE_downButton_InLow;
  logic            SC_FROGMOVE_leftButton_InLow;
  logic            SC_FROGMOVE_rightButton_InLow;
  logic            SC_FROGMOVE_enable_InHigh;
  logic [CW-1:0]   SC_FROGMOVE_col_Out;
  logic [RW-1:0]   SC_FROGMOVE_row_Out;
  logic [COLS-1:0] SC_FROGMOVE_colOneHot_Out;
  logic            SC_FROGMOVE_move_Out;
  logic            SC_FROGMOVE_blocked_Out;
  logic            SC_FROGMOVE_goal_Out;
  logic            SC_FROGMOVE_active_Out;

  modport master (
    output SC_FROGMOVE_startGame_InLow, SC_FROGMOVE_upButton_InLow,
           SC_FROGMOVE_downButton_InLow, SC_FROGMOVE_leftButton_InLow,
           SC_FROGMOVE_rightButton_InLow, SC_FROGMOVE_enable_InHigh,
    input  SC_FROGMOVE_col_Out, SC_FROGMOVE_row_Out, SC_FROGMOVE_colOneHot_Out,
           SC_FROGMOVE_move_Out, SC_FROGMOVE_blocked_Out, SC_FROGMOVE_goal_Out,
           SC_FROGMOVE_active_Out
  );

  modport slave (
    input  SC_FROGMOVE_startGame_InLow, SC_FROGMOVE_upButton_InLow,
           SC_FROGMOVE_downButton_InLow, SC_FROGMOVE_leftButton_InLow,
           SC_FROGMOVE_rightButton_InLow, SC_FROGMOVE_enable_InHigh,
    output SC_FROGMOVE_col_Out, SC_FROGMOVE_row_Out, SC_FROGMOVE_colOneHot_Out,
           SC_FROGMOVE_move_Out, SC_FROGMOVE_blocked_Out, SC_FROGMOVE_goal_Out,
           SC_FROGMOVE_active_Out
  );

endinterface
`default_nettype wire

// File: rtl/sc_frog_repeat_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_frog_repeat_timer : clear/increment counter with terminal-count compare
// Revision             : 1.0
// ---------------------------------------------------------------------------
module sc_frog_repeat_timer #(
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [TW-1:0] tc,
  output logic          done
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == tc);

endmodule
`default_nettype wire

// File: rtl/sc_frog_move_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sc_frog_move_ctrl : frog position FSM with edge clamping, goal detect and auto-repeat
// Revision          : 1.0
// ---------------------------------------------------------------------------
module sc_frog_move_ctrl
  import sc_frog_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int START_COL    = 3,
  parameter int START_ROW    = 0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input logic                SC_FROGMOVE_CLOCK_50,
  input logic                SC_FROGMOVE_RESET_InHigh,
  sc_frog_move_ctrl_if.slave bus
);

  localparam int CW   = width_of(COLS);
  localparam int RW   = width_of(ROWS);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = width_of(TMAX + 1);

  localparam logic [CW-1:0] COL_START = CW'(START_COL);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_PRE   = RW'(ROWS - 2);
  localparam logic [TW-1:0] DELAY_TC  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] RATE_TC   = TW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);

  logic clk;
  logic rst;
  assign clk = SC_FROGMOVE_CLOCK_50;
  assign rst = SC_FROGMOVE_RESET_InHigh;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    dir;
  logic          rep;

  logic [4:0]    pressed;   // {start, up, down, left, right}, 1 = held
  logic          all_released;
  logic          only_dir;
  logic          target_ok;
  logic          timer_clear;
  logic          timer_inc;
  logic          timer_done;
  logic [TW-1:0] timer_tc;

  assign pressed = ~{bus.SC_FROGMOVE_startGame_InLow, bus.SC_FROGMOVE_upButton_InLow,
                     bus.SC_FROGMOVE_downButton_InLow, bus.SC_FROGMOVE_leftButton_InLow,
                     bus.SC_FROGMOVE_rightButton_InLow};
  assign all_released = (pressed == 5'b00000);
  assign only_dir     = (pressed == {1'b0, dir_mask(dir)});
  assign timer_tc     = rep ? RATE_TC : DELAY_TC;

  always_comb begin
    target_ok = 1'b0;
    case (dir)
      DIR_UP:    target_ok = (row != ROW_LAST);
      DIR_DOWN:  target_ok = (row != '0);
      DIR_LEFT:  target_ok = (col != '0);
      DIR_RIGHT: target_ok = (col != COL_LAST);
      default:   target_ok = 1'b0;
    endcase
  end

  // Timer runs only while the latched direction alone is held; pause freezes it.
  always_comb begin
    timer_clear = 1'b1;
    timer_inc   = 1'b0;
    if (state == ST_HOLD && !all_released) begin
      if (!bus.SC_FROGMOVE_enable_InHigh) begin
        timer_clear = 1'b0;
      end else if (REPEAT_EN && only_dir && !timer_done) begin
        timer_clear = 1'b0;
        timer_inc   = 1'b1;
      end
    end
  end

  sc_frog_repeat_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .inc   (timer_inc),
    .tc    (timer_tc),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      col   <= COL_START;
      row   <= ROW_START;
      dir   <= DIR_UP;
      rep   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pressed[4]) state <= ST_INIT;
        end
        ST_INIT: begin
          col   <= COL_START;
          row   <= ROW_START;
          rep   <= 1'b0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.SC_FROGMOVE_enable_InHigh) begin
            if (pressed[4]) begin
              state <= ST_INIT;
            end else if (pressed[3]) begin
              dir <= DIR_UP;    state <= ST_MOVE;
            end else if (pressed[2]) begin
              dir <= DIR_DOWN;  state <= ST_MOVE;
            end else if (pressed[1]) begin
              dir <= DIR_LEFT;  state <= ST_MOVE;
            end else if (pressed[0]) begin
              dir <= DIR_RIGHT; state <= ST_MOVE;
            end
          end
        end
        ST_MOVE: begin
          if (target_ok) begin
            case (dir)
              DIR_UP:    row <= row + 1'b1;
              DIR_DOWN:  row <= row - 1'b1;
              DIR_LEFT:  col <= col - 1'b1;
              default:   col <= col + 1'b1;
            endcase
          end
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (all_released) begin
            rep   <= 1'b0;
            state <= ST_CHECK;
          end else if (bus.SC_FROGMOVE_enable_InHigh && REPEAT_EN && only_dir && timer_done) begin
            rep   <= 1'b1;
            state <= ST_MOVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SC_FROGMOVE_col_Out       = col;
  assign bus.SC_FROGMOVE_row_Out       = row;
  assign bus.SC_FROGMOVE_colOneHot_Out = COLS'(1) << col;
  assign bus.SC_FROGMOVE_move_Out      = (state == ST_MOVE) && target_ok;
  assign bus.SC_FROGMOVE_blocked_Out   = (state == ST_MOVE) && !target_ok;
  assign bus.SC_FROGMOVE_goal_Out      = (state == ST_MOVE) && target_ok &&
                                         (dir == DIR_UP) && (row == ROW_PRE);
  assign bus.SC_FROGMOVE_active_Out    = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sc_frog_move_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sc_frog_move_ctrl : directed bench, unit A without auto-repeat, unit B with delay 10 / rate 4
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_sc_frog_move_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sel_b   = 1'b0;
  logic b_start = 1'b1;
  logic b_up    = 1'b1;
  logic b_down  = 1'b1;
  logic b_left  = 1'b1;
  logic b_right = 1'b1;
  logic ena     = 1'b1;

  sc_frog_move_ctrl_if #(.COLS(8), .ROWS(8)) ifa ();
  sc_frog_move_ctrl_if #(.COLS(8), .ROWS(8)) ifb ();

  assign ifa.SC_FROGMOVE_startGame_InLow   = sel_b ? 1'b1 : b_start;
  assign ifa.SC_FROGMOVE_upButton_InLow    = sel_b ? 1'b1 : b_up;
  assign ifa.SC_FROGMOVE_downButton_InLow  = sel_b ? 1'b1 : b_down;
  assign ifa.SC_FROGMOVE_leftButton_InLow  = sel_b ? 1'b1 : b_left;
  assign ifa.SC_FROGMOVE_rightButton_InLow = sel_b ? 1'b1 : b_right;
  assign ifa.SC_FROGMOVE_enable_InHigh     = sel_b ? 1'b1 : ena;
  assign ifb.SC_FROGMOVE_startGame_InLow   = sel_b ? b_start : 1'b1;
  assign ifb.SC_FROGMOVE_upButton_InLow    = sel_b ? b_up    : 1'b1;
  assign ifb.SC_FROGMOVE_downButton_InLow  = sel_b ? b_down  : 1'b1;
  assign ifb.SC_FROGMOVE_leftButton_InLow  = sel_b ? b_left  : 1'b1;
  assign ifb.SC_FROGMOVE_rightButton_InLow = sel_b ? b_right : 1'b1;
  assign ifb.SC_FROGMOVE_enable_InHigh     = sel_b ? ena     : 1'b1;

  sc_frog_move_ctrl #(
    .COLS(8), .ROWS(8), .START_COL(3), .START_ROW(0), .REPEAT_DELAY(0), .REPEAT_RATE(1)
  ) u_dut_a (
    .SC_FROGMOVE_CLOCK_50     (clk),
    .SC_FROGMOVE_RESET_InHigh (rst),
    .bus                      (ifa)
  );

  sc_frog_move_ctrl #(
    .COLS(8), .ROWS(8), .START_COL(3), .START_ROW(0), .REPEAT_DELAY(10), .REPEAT_RATE(4)
  ) u_dut_b (
    .SC_FROGMOVE_CLOCK_50     (clk),
    .SC_FROGMOVE_RESET_InHigh (rst),
    .bus                      (ifb)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cur_col();
    return sel_b ? int'(ifb.SC_FROGMOVE_col_Out) : int'(ifa.SC_FROGMOVE_col_Out);
  endfunction
  function automatic int cur_row();
    return sel_b ? int'(ifb.SC_FROGMOVE_row_Out) : int'(ifa.SC_FROGMOVE_row_Out);
  endfunction
  function automatic int cur_hot();
    return sel_b ? int'(ifb.SC_FROGMOVE_colOneHot_Out) : int'(ifa.SC_FROGMOVE_colOneHot_Out);
  endfunction
  function automatic int cur_move();
    return sel_b ? int'(ifb.SC_FROGMOVE_move_Out) : int'(ifa.SC_FROGMOVE_move_Out);
  endfunction
  function automatic int cur_blk();
    return sel_b ? int'(ifb.SC_FROGMOVE_blocked_Out) : int'(ifa.SC_FROGMOVE_blocked_Out);
  endfunction
  function automatic int cur_goal();
    return sel_b ? int'(ifb.SC_FROGMOVE_goal_Out) : int'(ifa.SC_FROGMOVE_goal_Out);
  endfunction
  function automatic int cur_act();
    return sel_b ? int'(ifb.SC_FROGMOVE_active_Out) : int'(ifa.SC_FROGMOVE_active_Out);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: b_up    = v;
      1: b_down  = v;
      2: b_left  = v;
      default: b_right = v;
    endcase
  endtask

  // One press from CHECK: MOVE cycle pulses, then HOLD shows the new position.
  task automatic do_move(input string tag, input int b, input int em, input int eb,
                         input int eg, input int ec, input int er);
    set_btn(b, 1'b0);
    tick();
    check_eq({tag, " move"}, cur_move(), em);
    check_eq({tag, " blocked"}, cur_blk(), eb);
    check_eq({tag, " goal"}, cur_goal(), eg);
    set_btn(b, 1'b1);
    tick();
    check_eq({tag, " pulse width"}, cur_move() + cur_blk() + cur_goal(), 0);
    check_eq({tag, " col"}, cur_col(), ec);
    check_eq({tag, " row"}, cur_row(), er);
    check_eq({tag, " onehot"}, cur_hot(), 1 << ec);
    tick();
  endtask

  int mv;
  int bl;
  int nm;
  int mv_at[8];
  int exp_at[7] = '{1, 12, 17, 22, 27, 32, 37};

  initial begin
    repeat (2) tick();
    check_eq("reset active", cur_act(), 0);
    check_eq("reset col", cur_col(), 3);
    check_eq("reset row", cur_row(), 0);
    check_eq("reset pulses", cur_move() + cur_blk() + cur_goal(), 0);
    rst = 1'b0;
    tick();
    b_up = 1'b0;
    repeat (3) tick();
    check_eq("idle ignores dir", cur_row(), 0);
    check_eq("idle inactive", cur_act(), 0);
    b_up = 1'b1;
    tick();

    b_start = 1'b0;
    tick();
    b_start = 1'b1;
    check_eq("init active", cur_act(), 1);
    tick();
    check_eq("check col", cur_col(), 3);
    check_eq("check row", cur_row(), 0);
    check_eq("check pulses", cur_move() + cur_blk() + cur_goal(), 0);

    // Up held: one move, then nothing while held with repeat disabled.
    b_up = 1'b0;
    tick();
    check_eq("up move pulse", cur_move(), 1);
    check_eq("up row not yet", cur_row(), 0);
    tick();
    check_eq("up move ends", cur_move(), 0);
    check_eq("up row", cur_row(), 1);
    mv = 0;
    repeat (8) begin
      tick();
      mv += cur_move();
    end
    check_eq("held no repeat", mv, 0);
    check_eq("held row", cur_row(), 1);
    b_up = 1'b1;
    tick();

    do_move("down r1", 1, 1, 0, 0, 3, 0);
    do_move("down r0", 1, 0, 1, 0, 3, 0);
    do_move("left c2", 2, 1, 0, 0, 2, 0);
    do_move("left c1", 2, 1, 0, 0, 1, 0);
    do_move("left c0", 2, 1, 0, 0, 0, 0);
    do_move("left edge", 2, 0, 1, 0, 0, 0);
    for (int c = 1; c <= 7; c++) do_move("right", 3, 1, 0, 0, c, 0);
    do_move("right edge", 3, 0, 1, 0, 7, 0);
    for (int r = 1; r <= 6; r++) do_move("up", 0, 1, 0, 0, 7, r);
    do_move("up goal", 0, 1, 0, 1, 7, 7);
    do_move("up top edge", 0, 0, 1, 0, 7, 7);

    b_start = 1'b0;
    tick();
    b_start = 1'b1;
    check_eq("restart active", cur_act(), 1);
    tick();
    check_eq("restart col", cur_col(), 3);
    check_eq("restart row", cur_row(), 0);

    ena  = 1'b0;
    b_up = 1'b0;
    mv   = 0;
    repeat (20) begin
      tick();
      mv += cur_move();
    end
    check_eq("pause no move", mv, 0);
    check_eq("pause row", cur_row(), 0);
    b_up = 1'b1;
    tick();
    ena = 1'b1;
    tick();
    check_eq("unpause row", cur_row(), 0);

    // Unit B: auto-repeat with delay 10, rate 4.
    sel_b   = 1'b1;
    b_start = 1'b0;
    tick();
    b_start = 1'b1;
    tick();
    check_eq("B start col", cur_col(), 3);
    do_move("B left c2", 2, 1, 0, 0, 2, 0);
    do_move("B left c1", 2, 1, 0, 0, 1, 0);
    do_move("B left c0", 2, 1, 0, 0, 0, 0);
    b_right = 1'b0;
    nm = 0;
    bl = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cur_move() == 1) begin
        if (nm < 8) mv_at[nm] = i;
        nm++;
      end
      bl += cur_blk();
    end
    check_eq("B repeat count", nm, 7);
    for (int k = 0; k < 7; k++) check_eq($sformatf("B repeat %0d at", k), mv_at[k], exp_at[k]);
    check_eq("B repeat col", cur_col(), 7);
    check_eq("B repeat blocked", bl, 0);

    // Reset mid-HOLD with right still held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("B rst active", cur_act(), 0);
    check_eq("B rst col", cur_col(), 3);
    check_eq("B rst row", cur_row(), 0);
    repeat (5) tick();
    check_eq("B idle col", cur_col(), 3);
    b_right = 1'b1;
    b_up    = 1'b0;
    mv = 0;
    repeat (5) begin
      tick();
      mv += cur_move();
    end
    check_eq("B idle no move", mv, 0);
    check_eq("B idle inactive", cur_act(), 0);
    b_up = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
